shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 98 +++++++++
 tb/tb_shift_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Sequences the WIDTH-bit load/shift-right datapath through load, N shifts and capture. A start is answered with done N+3 cycles later.
// There is no backpressure: start is ignored, not queued, while busy. clear and reset abort an operation and zero the datapath.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  input  logic [AMT_W-1:0] amount,
  input  logic             arith,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] sh_load_val,
  output logic             sh_load_n,
  output logic             sh_shift,
  output logic             sh_asr,
  output logic             sh_reset_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] val_q;
  logic [AMT_W-1:0] amt_q;
  logic             arith_q;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] amt_sat;

  // Shifting WIDTH or more places leaves only fill bits, so larger amounts collapse to WIDTH.
  always_comb begin
    amt_sat = amount;
    if (32'(amount) >= WIDTH) amt_sat = AMT_W'(WIDTH);
  end

  assign sh_reset_n  = ~(reset | clear);
  assign sh_load_n   = (state != LOAD);
  assign sh_shift    = (state == SHIFT);
  assign busy        = (state != IDLE);
  assign sh_asr      = arith_q;
  assign sh_load_val = val_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      val_q   <= '0;
      amt_q   <= '0;
      arith_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            val_q   <= load_val;
            amt_q   <= amt_sat;
            arith_q <= arith;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (amt_q == '0) begin
            state <= CAPTURE;
          end else begin
            cnt   <= amt_q;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          result <= q_in;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Drives shift_sequencer against a behavioural 8-bit shift register and checks results and latency through a scoreboard.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] amount = 4'h0;
  logic       arith = 1'b0;
  logic [7:0] q;
  logic [7:0] sh_load_val;
  logic       sh_load_n, sh_shift, sh_asr, sh_reset_n, busy, done;
  logic [7:0] result;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] last_res = 8'h00;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .load_val(load_val), .amount(amount), .arith(arith), .q_in(q),
    .sh_load_val(sh_load_val), .sh_load_n(sh_load_n), .sh_shift(sh_shift),
    .sh_asr(sh_asr), .sh_reset_n(sh_reset_n), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The load/shift-right register the controller is meant to drive.
  always @(posedge clk) begin
    if (!sh_reset_n)    q <= 8'h00;
    else if (!sh_load_n) q <= sh_load_val;
    else if (sh_shift)  q <= sh_asr ? {q[7], q[7:1]} : {1'b0, q[7:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] val, input int amt, input logic ar);
    int n;
    n = (amt > 8) ? 8 : amt;
    if (ar) return 8'($signed(val) >>> n);
    return val >> n;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("done_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge with the controller idle; returns at the negedge of the done (or abort) cycle.
  // abort_kind: 0 none, 1 clear, 2 reset; abort_at is the busy-cycle index (0 = LOAD) in which it fires.
  task automatic run_op(input logic [7:0] val, input int amt, input logic ar,
                        input int abort_kind, input int abort_at, input bit noise);
    int k, n, busy_cnt;
    bit finished;
    n = (amt > 8) ? 8 : amt;
    start = 1'b1; load_val = val; amount = 4'(amt); arith = ar;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
    load_val = 8'($urandom); amount = 4'($urandom); arith = 1'($urandom);
    if (abort_kind == 0) sb.push_back('{res: model(val, amt, ar), cyc: k + n + 2});
    busy_cnt = 0;
    finished = 0;
    for (int i = 0; i < 40 && !finished; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        start = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'(n + 2));
        last_res = model(val, amt, ar);
        finished = 1;
      end else begin
        if (busy_cnt == 0) begin
          check("sh_asr", 32'(sh_asr), 32'(ar));
          check("sh_load_val", 32'(sh_load_val), 32'(val));
        end
        if (abort_kind != 0 && busy_cnt == abort_at) begin
          start = 1'b0;
          if (abort_kind == 1) clear = 1'b1; else reset = 1'b1;
          #1 check("sh_reset_n_abort", 32'(sh_reset_n), 32'd0);
          @(posedge clk); #1;
          clear = 1'b0; reset = 1'b0;
          @(negedge clk);
          if (abort_kind == 2) last_res = 8'h00;
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_q", 32'(q), 32'd0);
          check("abort_result", 32'(result), 32'(last_res));
          return;
        end
        busy_cnt++;
        start = noise ? 1'($urandom) : 1'b0;
        if (start) begin
          load_val = 8'($urandom); amount = 4'($urandom); arith = 1'($urandom);
        end
      end
    end
    if (!finished) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int amt, ab, kind;
    @(negedge clk);
    check("reset_sh_reset_n", 32'(sh_reset_n), 32'd0);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_sh_load_n", 32'(sh_load_n), 32'd1);
    check("reset_sh_shift", 32'(sh_shift), 32'd0);
    check("reset_q", 32'(q), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'hB4, 2, 1'b0, 0, 0, 0);
    idle_cycles(2);
    run_op(8'h96, 3, 1'b1, 0, 0, 0);
    idle_cycles(1);
    run_op(8'h5A, 0, 1'b0, 0, 0, 0);
    idle_cycles(1);
    run_op(8'h80, 15, 1'b1, 0, 0, 0);
    idle_cycles(1);
    run_op(8'h80, 15, 1'b0, 0, 0, 0);
    idle_cycles(1);
    run_op(8'hC3, 5, 1'b0, 1, 2, 0);
    idle_cycles(1);
    run_op(8'hE7, 4, 1'b1, 0, 0, 1);
    run_op(8'h0F, 1, 1'b0, 0, 0, 0);
    run_op(8'hA5, 6, 1'b1, 2, 2, 0);
    idle_cycles(1);

    for (int t = 0; t < 40; t++) begin
      amt = $urandom_range(0, 15);
      kind = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      ab = $urandom_range(0, ((amt > 8) ? 8 : amt) + 1);
      run_op(8'($urandom), amt, 1'($urandom), kind, ab, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
